// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: one full-add slice (two half adders plus a carry
// flop) is reused across all operand bits, LSB first, one bit per clock.

module hadder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s0;
  logic             w_c0;
  logic             w_s;
  logic             w_c1;
  logic             w_carry_next;
  logic [WIDTH:0]   w_sr_cat;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_accept;
  logic             w_last;

  hadder u_h0 (
    .i_a (r_sa[0]),
    .i_b (r_sb[0]),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  hadder u_h1 (
    .i_a (w_s0),
    .i_b (r_carry),
    .o_s (w_s),
    .o_c (w_c1)
  );

  assign w_carry_next = w_c0 | w_c1;
  // Concatenate-then-slice keeps the result shift legal when WIDTH is 1.
  assign w_sr_cat     = {w_s, r_sr};
  assign w_sr_next    = w_sr_cat[WIDTH:1];

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_sa    <= a;
      r_sb    <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_sr    <= w_sr_next;
      r_carry <= w_carry_next;
      r_cnt   <= r_cnt + CW'(1);
      // Publish only on the final bit so sum/cout never show partial results.
      if (w_last) begin
        r_sum  <= w_sr_next;
        r_cout <= w_carry_next;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq (WIDTH=8 and WIDTH=1 instances)
// against a cycle-level behavioural model of the start/busy/done contract.

module tb_serial_adder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       rst1, start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  serial_adder_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_seq #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: an accepted request completes exactly w edges later with a+b+cin.
  bit m_active   [2] = '{0, 0};
  int m_done_cyc [2] = '{0, 0};
  int m_cyc      [2] = '{0, 0};
  int m_res      [2] = '{0, 0};
  int m_sum      [2] = '{0, 0};
  bit m_busy     [2] = '{0, 0};
  bit m_done     [2] = '{0, 0};
  bit m_cout     [2] = '{0, 0};

  task automatic model_step(input int k, input int w, input bit r, input bit st,
                            input int a, input int b, input bit c);
    bit was;
    m_cyc[k]++;
    if (r) begin
      m_active[k] = 0; m_busy[k] = 0; m_done[k] = 0;
      m_sum[k] = 0;    m_cout[k] = 0;
    end else begin
      was       = m_active[k];
      m_done[k] = 0;
      if (was && m_cyc[k] == m_done_cyc[k]) begin
        m_sum[k]    = m_res[k] & ((1 << w) - 1);
        m_cout[k]   = ((m_res[k] >> w) & 1) != 0;
        m_done[k]   = 1;
        m_active[k] = 0;
      end
      if (!was && st) begin
        m_active[k]   = 1;
        m_done_cyc[k] = m_cyc[k] + w;
        m_res[k]      = a + b + int'(c);
      end
      m_busy[k] = m_active[k];
    end
  endtask

  always @(posedge clk or posedge rst8)
    model_step(0, 8, rst8, start8, int'(a8), int'(b8), cin8);
  always @(posedge clk or posedge rst1)
    model_step(1, 1, rst1, start1, int'(a1), int'(b1), cin1);

  always @(negedge clk) begin
    if (cmp_en) begin
      check("w8 busy", int'(busy8), int'(m_busy[0]));
      check("w8 done", int'(done8), int'(m_done[0]));
      check("w8 sum",  int'(sum8),  m_sum[0]);
      check("w8 cout", int'(cout8), int'(m_cout[0]));
      check("w1 busy", int'(busy1), int'(m_busy[1]));
      check("w1 done", int'(done1), int'(m_done[1]));
      check("w1 sum",  int'(sum1),  m_sum[1]);
      check("w1 cout", int'(cout1), int'(m_cout[1]));
    end
  end

  // Caller is at posedge+1; start is held for exactly the accepting edge.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic ec,
                         input string name, input bit noise);
    int lat;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (noise && i < 7) begin
        start8 = 1'($urandom_range(0, 1));
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
      end else begin
        start8 = 1'b0;
      end
      if (done8) begin lat = i; break; end
    end
    check({name, " latency"}, lat, 8);
    check({name, " sum"}, int'(sum8), int'(es));
    check({name, " cout"}, int'(cout8), int'(ec));
    check({name, " model sum"}, m_sum[0], int'(es));
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, lat2, ndone, r, g;
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy8", int'(busy8), 0);
    check("reset done8", int'(done8), 0);
    check("reset sum8",  int'(sum8),  0);
    check("reset cout8", int'(cout8), 0);
    check("reset busy1", int'(busy1), 0);
    rst8 = 1'b0; rst1 = 1'b0; cmp_en = 1'b1;

    run_op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "add 00+00", 0);
    run_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add FF+01", 0);
    run_op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "add A5+5A+1", 0);
    run_op8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "add 3C+42", 0);

    // Start and operand changes while busy must be ignored.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; ndone = 0; lat = 99;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
      else start8 = 1'b0;
      if (i == 7) begin
        check("busy hold sum", int'(sum8), 8'h7E);
        check("busy hold busy", int'(busy8), 1);
      end
      if (done8) begin ndone++; lat = i; end
    end
    check("ignore latency", lat, 8);
    check("ignore done count", ndone, 1);
    check("ignore sum", int'(sum8), 8'h46);
    check("ignore cout", int'(cout8), 0);

    // Asynchronous reset in the middle of a computation.
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst8 = 1'b1;
    #1;
    check("midrst busy", int'(busy8), 0);
    check("midrst done", int'(done8), 0);
    check("midrst sum",  int'(sum8),  0);
    check("midrst cout", int'(cout8), 0);
    @(posedge clk); #1;
    rst8 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    check("midrst no done", ndone, 0);
    run_op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post-reset 01+01", 0);

    // Back-to-back: start held through the DONE cycle.
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h80;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done8) begin lat = i; break; end
    end
    check("b2b first latency", lat, 8);
    check("b2b first sum", int'(sum8), 8'h30);
    check("b2b first cout", int'(cout8), 0);
    lat2 = 99;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      if (done8) begin lat2 = j; break; end
    end
    check("b2b spacing", lat2, 9);
    check("b2b second sum", int'(sum8), 8'h00);
    check("b2b second cout", int'(cout8), 1);

    // WIDTH=1 exhaustive.
    for (int k = 0; k < 8; k++) begin
      a1 = k[2]; b1 = k[1]; cin1 = k[0]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      lat = 99;
      for (int i = 1; i <= 5; i++) begin
        @(posedge clk); #1;
        if (done1) begin lat = i; break; end
      end
      check($sformatf("w1 combo%0d latency", k), lat, 1);
      check($sformatf("w1 combo%0d result", k), int'({cout1, sum1}),
            int'(k[2]) + int'(k[1]) + int'(k[0]));
    end

    // Randomized operands, with start/operand noise while busy.
    for (int n = 0; n < 200; n++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
      r  = int'(ra) + int'(rb) + int'(rc);
      run_op8(ra, rb, rc, r[7:0], r[8], $sformatf("rand%0d", n), 1);
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_seq.md
# serial_adder_seq

Bit-serial WIDTH-bit adder controller. It time-multiplexes one 1-bit full-add slice, built from two `hadder` instances plus a carry flop, across all operand bits, one bit per clock. A start/busy/done handshake sequences it. Upstream control logic uses it when area matters more than latency.

## Interface

Parameters:
- `WIDTH`, default 8: operand and result width in bits.
  - Legal range is WIDTH ≥ 1.
  - The bit counter is $clog2(WIDTH+1) bits wide.

Ports:
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request an addition. Sampled only when `busy`=0.
- `a`, input, WIDTH: operand A. Captured on the accepting edge.
- `b`, input, WIDTH: operand B. Captured on the accepting edge.
- `cin`, input, 1: carry-in. Captured on the accepting edge.
- `busy`, output, 1: an operation is in progress. New starts are ignored.
- `done`, output, 1: one-cycle pulse marking `sum`/`cout` as freshly valid.
- `sum`, output, WIDTH: result register. Holds its value between operations.
- `cout`, output, 1: carry-out register. Holds its value between operations.

## Operation

FSM states:

- **IDLE**
  - `busy`=0.
  - On `start`=1: load shift registers `sa`←`a`, `sb`←`b`; carry flop←`cin`; counter←0; `busy`←1; go to RUN.
  - On `start`=0: stay in IDLE.
- **RUN**
  - Datapath per cycle:
    - hadder h0 takes (`sa[0]`, `sb[0]`) and produces `s0`, `c0`.
    - hadder h1 takes (`s0`, carry) and produces `s`, `c1`.
  - On each edge:
    - carry←`c0`|`c1`.
    - `sa`, `sb` shift right by one.
    - Result shift register `sr`←{`s`, `sr[WIDTH-1:1]`}.
    - counter←counter+1.
  - When counter = WIDTH-1 (the last bit):
    - `sum`←final `sr` value, including the current bit `s` at the MSB.
    - `cout`←`c0`|`c1`.
    - `done`←1, `busy`←0.
    - Go to DONE.
- **DONE**
  - Lasts exactly one cycle. `done`=1 and `busy`=0 during it.
  - On `start`=1: accept exactly as in IDLE (back-to-back operation) and go to RUN.
  - Otherwise: go to IDLE.
  - `done` clears on the next edge in either case.

Rules:
- `start` while `busy`=1 is ignored; no queuing.
- Changes to `a`, `b`, `cin` while busy have no effect.
- `sum` and `cout` change only on the completing edge. They are never seen mid-computation.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, computed modulo 2^(WIDTH+1). No overflow flag.
- Reset, at any time including mid-RUN:
  - Immediately, asynchronously: state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, counter=0, carry=0, shift registers=0.
  - The in-flight operation is discarded.
  - After `rst` deasserts, the first `start` is accepted on the first rising edge with `rst`=0.

## Timing

- Let edge E0 be the edge where `start` is accepted.
- `busy` is high after E0 through edge E0+WIDTH.
- The completion edge is E0+WIDTH. After it, `done`=1 and `sum`/`cout` are valid.
- Latency from accept to `done` is WIDTH cycles.
- `done` is high for exactly one cycle.
- Throughput with back-to-back starts: one result per WIDTH+1 cycles.
- Reset values: all outputs are 0.

## Test plan

- **Basic adds**, WIDTH=8:
  - `a`=0x00, `b`=0x00, `cin`=0, start pulse → `done` 8 cycles later, `sum`=0x00, `cout`=0.
  - `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1.
  - `a`=0xA5, `b`=0x5A, `cin`=1 → `sum`=0x00, `cout`=1.
  - `a`=0x3C, `b`=0x42, `cin`=0 → `sum`=0x7E, `cout`=0.
- **Ignored inputs while busy**, WIDTH=8:
  - Start 0x12+0x34; then 3 cycles later assert `start` and change `a`/`b` to 0xFF.
  - Required: result 0x46, `cout`=0; exactly one `done` pulse; `sum` unchanged before the completion edge.
- **Reset mid-operation**, WIDTH=8:
  - Start 0xFF+0xFF; assert `rst` at cycle 4.
  - Required: all outputs 0 immediately, no `done`.
  - Then start 0x01+0x01 → `sum`=0x02 after 8 cycles.
- **Back-to-back**, WIDTH=8:
  - Start 0x10+0x20; hold `start`=1 through the DONE cycle with new operands 0x80+0x80.
  - Required: first `done` with 0x30/`cout`=0; second `done` 9 cycles later with 0x00/`cout`=1.
- **Exhaustive, WIDTH=1**:
  - All 8 combinations of (`a`,`b`,`cin`).
  - Required: {`cout`,`sum`} = `a`+`b`+`cin`, with `done` 1 cycle after accept for every combination.
- **Randomized self-check, WIDTH=8**:
  - 200 random operand sets, checked against `a`+`b`+`cin`.
